// File: rtl/iic_reg_target.sv
// I2C register target: filtered bus inputs, address match, auto-incrementing register file.
// IIC_WRITE_LOCK_EN: writes to registers other than reg1 commit only while reg1[7:5]==3'b111.
module iic_reg_target #(
  parameter logic [6:0] DEV_ADDR = 7'h60,
  parameter int         NREG     = 4,
  parameter int         FILT     = 3,
  localparam int        PW       = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_is_out,
  output logic              wr_stb,
  output logic [PW-1:0]     wr_addr,
  output logic [NREG*8-1:0] regs_o,
  output logic              busy
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ACK_A, REG, ACK_R, WDAT, ACK_W, RDAT, MACK
  } st_t;

  // bit 0 = SCL, bit 1 = SDA through the synchroniser and filter
  logic [1:0]         s1_q, s1_d, s2_q, s2_d, flt_q, flt_d, prv_q, prv_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;

  st_t                st_q, st_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         sh_q, sh_d;
  logic               rw_q, rw_d;
  logic               ph_q, ph_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [NREG*8-1:0]  regs_q, regs_d;
  logic [PW-1:0]      wr_addr_q, wr_addr_d;
  logic               wr_stb_q, wr_stb_d;
  logic               sdo_q, sdo_d;
  logic               busy_q, busy_d;

  logic               scl_lvl, sda_lvl, scl_r, scl_f, start, stop;
  logic [7:0]         rx_byte, cur_reg;
  logic [PW-1:0]      ptr_inc;
  logic               wr_ok;

  always_comb begin
    s1_d   = {sda_i, scl_i};
    s2_d   = s1_q;
    prv_d  = flt_q;
    flt_d  = flt_q;
    fcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != flt_q[i]) begin
        if (fcnt_q[i] == FW'(FILT - 1)) flt_d[i] = s2_q[i];
        else                            fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign scl_lvl = flt_q[0];
  assign sda_lvl = flt_q[1];
  assign scl_r   = scl_lvl & ~prv_q[0];
  assign scl_f   = ~scl_lvl & prv_q[0];
  // both conditions require SCL high with no edge, so they never coincide with scl_r/scl_f
  assign start   = scl_lvl & prv_q[0] & prv_q[1] & ~sda_lvl;
  assign stop    = scl_lvl & prv_q[0] & ~prv_q[1] & sda_lvl;

  always_comb begin
    st_d      = st_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    ph_d      = ph_q;
    ptr_d     = ptr_q;
    regs_d    = regs_q;
    wr_addr_d = wr_addr_q;
    wr_stb_d  = 1'b0;
    sdo_d     = sdo_q;
    busy_d    = busy_q;
    rx_byte   = {sh_q[6:0], sda_lvl};
    cur_reg   = regs_q[{ptr_q, 3'b000} +: 8];
    ptr_inc   = (ptr_q == PW'(NREG - 1)) ? '0 : ptr_q + 1'b1;
`ifdef IIC_WRITE_LOCK_EN
    wr_ok     = (ptr_q == PW'(1)) || (regs_q[15:13] == 3'b111);
`else
    wr_ok     = 1'b1;
`endif

    if (start) begin
      st_d   = ADDR;
      cnt_d  = '0;
      ph_d   = 1'b0;
      sdo_d  = 1'b0;
      busy_d = 1'b1;
    end else if (stop) begin
      st_d   = IDLE;
      ph_d   = 1'b0;
      sdo_d  = 1'b0;
      busy_d = 1'b0;
    end else begin
      case (st_q)
        IDLE: ;
        ADDR: if (scl_r) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (rx_byte[7:1] == DEV_ADDR) begin
              st_d = ACK_A;
              rw_d = rx_byte[0];
            end else begin
              st_d   = IDLE;
              sdo_d  = 1'b0;
              busy_d = 1'b0;
            end
          end
        end
        REG: if (scl_r) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            ptr_d = PW'(rx_byte % NREG);
            st_d  = ACK_R;
          end
        end
        WDAT: if (scl_r) begin
          sh_d  = rx_byte;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (wr_ok) begin
              regs_d[{ptr_q, 3'b000} +: 8] = rx_byte;
              wr_stb_d  = 1'b1;
              wr_addr_d = ptr_q;
            end
            ptr_d = ptr_inc;
            st_d  = ACK_W;
          end
        end
        // ph_q=0: waiting for the fall ending bit 8; ph_q=1: holding ACK through bit 9
        ACK_A, ACK_R, ACK_W: if (scl_f) begin
          if (!ph_q) begin
            sdo_d = 1'b1;
            ph_d  = 1'b1;
          end else begin
            ph_d  = 1'b0;
            sdo_d = 1'b0;
            cnt_d = '0;
            if (st_q == ACK_A && rw_q) begin
              st_d  = RDAT;
              sdo_d = ~cur_reg[7];
              sh_d  = {cur_reg[6:0], 1'b0};
              cnt_d = 4'd1;
            end else if (st_q == ACK_A) begin
              st_d = REG;
            end else begin
              st_d = WDAT;
            end
          end
        end
        // sh_q[7] holds the next bit to put on the bus; cnt_q counts bits already driven
        RDAT: if (scl_f) begin
          if (cnt_q == 4'd8) begin
            sdo_d = 1'b0;
            cnt_d = '0;
            ph_d  = 1'b0;
            st_d  = MACK;
          end else begin
            sdo_d = ~sh_q[7];
            sh_d  = {sh_q[6:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
          end
        end
        MACK: begin
          if (scl_r) begin
            if (sda_lvl) begin
              st_d   = IDLE;
              busy_d = 1'b0;
            end else begin
              ptr_d = ptr_inc;
              ph_d  = 1'b1;
            end
          end else if (scl_f && ph_q) begin
            ph_d  = 1'b0;
            st_d  = RDAT;
            sdo_d = ~cur_reg[7];
            sh_d  = {cur_reg[6:0], 1'b0};
            cnt_d = 4'd1;
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 2'b11;
      s2_q      <= 2'b11;
      flt_q     <= 2'b11;
      prv_q     <= 2'b11;
      fcnt_q    <= '0;
      st_q      <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      ph_q      <= 1'b0;
      ptr_q     <= '0;
      regs_q    <= '0;
      wr_addr_q <= '0;
      wr_stb_q  <= 1'b0;
      sdo_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      flt_q     <= flt_d;
      prv_q     <= prv_d;
      fcnt_q    <= fcnt_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      ph_q      <= ph_d;
      ptr_q     <= ptr_d;
      regs_q    <= regs_d;
      wr_addr_q <= wr_addr_d;
      wr_stb_q  <= wr_stb_d;
      sdo_q     <= sdo_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_o      = 1'b0;
  assign sda_is_out = sdo_q;
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign regs_o     = regs_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_iic_reg_target.sv
// Bit-banged I2C master driving iic_reg_target through an open-drain SDA model.
module tb_iic_reg_target;
  localparam int FILT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_o, sda_is_out, wr_stb, busy;
  logic [1:0]  wr_addr;
  logic [31:0] regs_o;
  logic        sda_bus;
  int          total = 0;
  int          bad = 0;
  int          stb_cnt = 0;

  assign sda_bus = sda_is_out ? (sda_m & sda_o) : sda_m;

  iic_reg_target #(.DEV_ADDR(7'h60), .NREG(4), .FILT(FILT)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_o      (sda_o),
    .sda_is_out (sda_is_out),
    .wr_stb     (wr_stb),
    .wr_addr    (wr_addr),
    .regs_o     (regs_o),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (wr_stb === 1'b1) stb_cnt <= stb_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    wait_clks(5);  sda_m = 1'b1;
    wait_clks(10); scl_m = 1'b1;
    wait_clks(10); sda_m = 1'b0;
    wait_clks(10); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(5);  sda_m = 1'b0;
    wait_clks(10); scl_m = 1'b1;
    wait_clks(10); sda_m = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    wait_clks(5);  sda_m = b;
    wait_clks(10); scl_m = 1'b1;
    wait_clks(4);
    if (glitch) begin
      sda_m = ~b;
      wait_clks(FILT - 1);
      sda_m = b;
    end
    wait_clks(6);  scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_clks(5);  sda_m = 1'b1;
    wait_clks(10); scl_m = 1'b1;
    wait_clks(5);  b = sda_bus;
    wait_clks(5);  scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0);
  endtask

  task automatic wr_txn(input logic [7:0] ra, input logic [7:0] d0, input logic [7:0] d1,
                        input logic two, output logic [3:0] acks);
    logic a0, a1, a2, a3;
    i2c_start();
    send_byte(8'hC0, a0);
    send_byte(ra, a1);
    send_byte(d0, a2);
    a3 = 1'b0;
    if (two) send_byte(d1, a3);
    i2c_stop();
    acks = {a0, a1, a2, a3};
  endtask

  initial begin
    logic [3:0] acks;
    logic       a0, a1, a2;
    logic [7:0] d0, d1;
    logic [7:0] addr_w;
    int         base;

    wait_clks(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sda_is_out", {31'd0, sda_is_out}, 32'd0);
    check("rst_sda_o", {31'd0, sda_o}, 32'd0);
    check("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    check("rst_regs", regs_o, 32'h0);
    rst = 1'b0;
    wait_clks(10);

`ifdef IIC_WRITE_LOCK_EN
    base = stb_cnt;
    wr_txn(8'h00, 8'h55, 8'h00, 1'b0, acks);
    check("lock_acks", {28'd0, acks}, 32'd0);
    check("lock_regs", regs_o, 32'h0);
    check("lock_stb", stb_cnt - base, 32'd0);
`endif

    // single write to reg1
    base = stb_cnt;
    i2c_start();
    check("t1_busy_on", {31'd0, busy}, 32'd1);
    send_byte(8'hC0, a0);
    send_byte(8'h01, a1);
    send_byte(8'hE0, a2);
    i2c_stop();
    check("t1_acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t1_stb", stb_cnt - base, 32'd1);
    check("t1_wr_addr", {30'd0, wr_addr}, 32'd1);
    check("t1_regs", regs_o, 32'h0000E000);
    check("t1_busy_off", {31'd0, busy}, 32'd0);

    // wrong address
    i2c_start();
    send_byte(8'hC2, a0);
    check("t2_nack", {31'd0, a0}, 32'd1);
    check("t2_busy", {31'd0, busy}, 32'd0);
    i2c_stop();
    check("t2_regs", regs_o, 32'h0000E000);

`ifdef IIC_WRITE_LOCK_EN
    base = stb_cnt;
    wr_txn(8'h00, 8'h55, 8'h00, 1'b0, acks);
    check("unlock_regs", regs_o, 32'h0000E055);
    check("unlock_stb", stb_cnt - base, 32'd1);
`endif

    // auto-increment write wrapping from reg3 to reg0
    base = stb_cnt;
    wr_txn(8'h03, 8'h11, 8'h22, 1'b1, acks);
    check("t3_acks", {28'd0, acks}, 32'd0);
    check("t3_stb", stb_cnt - base, 32'd2);
    check("t3_regs", regs_o, 32'h1100E022);
    check("t3_wr_addr", {30'd0, wr_addr}, 32'd0);

    // pointer write, repeated START, two-byte read
    i2c_start();
    send_byte(8'hC0, a0);
    send_byte(8'h00, a1);
    i2c_start();
    send_byte(8'hC1, a2);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop();
    check("t4_acks", {29'd0, a0, a1, a2}, 32'd0);
    check("t4_byte0", {24'd0, d0}, 32'h22);
    check("t4_byte1", {24'd0, d1}, 32'hE0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_release", {31'd0, sda_is_out}, 32'd0);

    // would-be START glitch on an idle bus
    wait_clks(10);
    sda_m = 1'b0;
    wait_clks(FILT - 1);
    sda_m = 1'b1;
    wait_clks(20);
    check("t5_idle_glitch", {31'd0, busy}, 32'd0);

    // would-be STOP glitch inside the address byte, then reset while ACK is driven
    addr_w = 8'hC0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(addr_w[i], i == 5);
    wait_clks(12);
    check("t5_ack_drive", {31'd0, sda_is_out}, 32'd1);
    check("t5_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    wait_clks(1);
    check("t5_rst_release", {31'd0, sda_is_out}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_regs", regs_o, 32'h0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clks(10);
    rst = 1'b0;
    wait_clks(20);

    // normal operation after reset
    base = stb_cnt;
    wr_txn(8'h02, 8'h5A, 8'h00, 1'b0, acks);
    check("t6_acks", {28'd0, acks}, 32'd0);
`ifdef IIC_WRITE_LOCK_EN
    check("t6_regs", regs_o, 32'h0);
    check("t6_stb", stb_cnt - base, 32'd0);
    check("t6_wr_addr", {30'd0, wr_addr}, 32'd0);
`else
    check("t6_regs", regs_o, 32'h005A0000);
    check("t6_stb", stb_cnt - base, 32'd1);
    check("t6_wr_addr", {30'd0, wr_addr}, 32'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
